// File: rtl/rx_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_parser
// Purpose  : Parses a UART byte stream framed as SYNC, THRESH, LEN_HI, LEN_LO
//            followed by LEN pixel bytes, and queues the pixels (with an
//            end-of-frame marker) in a show-ahead FIFO for a downstream
//            consumer using a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module rx_frame_parser #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter logic [7:0]  THRESH_RST = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] din,
  output logic [7:0] pix_data,
  output logic       pix_last,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [7:0] thresh,
  output logic       frame_active,
  output logic       ovf_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] c_fifo_full = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] c_cnt_one   = CW'(1);
  localparam logic [AW-1:0] c_ptr_one   = AW'(1);

  localparam logic [2:0] S_WAIT_SYNC  = 3'd0;
  localparam logic [2:0] S_GET_THR    = 3'd1;
  localparam logic [2:0] S_GET_LEN_HI = 3'd2;
  localparam logic [2:0] S_GET_LEN_LO = 3'd3;
  localparam logic [2:0] S_PIXELS     = 3'd4;

  logic [2:0]    r_state;
  logic [7:0]    r_thresh;
  logic [7:0]    r_len_hi;
  logic [15:0]   r_remaining;
  logic          r_ovf;

  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [15:0]   w_len;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_req;
  logic          w_wr;
  logic          w_drop;
  logic          w_last_px;

  // The full 16-bit length is only ever needed on the LEN_LO byte itself.
  assign w_len      = {r_len_hi, din};
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_fifo_full);
  assign w_pop      = ~w_empty & pix_ready;
  assign w_push_req = rx_done_tick & (r_state == S_PIXELS);
  // A simultaneous pop frees a slot, so a full FIFO still accepts the byte.
  assign w_wr       = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_last_px  = (r_remaining == 16'd1);

  // Frame parser: advances one step per received byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_WAIT_SYNC;
      r_thresh    <= THRESH_RST;
      r_len_hi    <= 8'd0;
      r_remaining <= 16'd0;
      r_ovf       <= 1'b0;
    end else if (rx_done_tick) begin
      case (r_state)
        S_WAIT_SYNC: begin
          if (din == SYNC_BYTE) begin
            r_state <= S_GET_THR;
            r_ovf   <= 1'b0;
          end
        end
        S_GET_THR: begin
          r_thresh <= din;
          r_state  <= S_GET_LEN_HI;
        end
        S_GET_LEN_HI: begin
          r_len_hi <= din;
          r_state  <= S_GET_LEN_LO;
        end
        S_GET_LEN_LO: begin
          if (w_len == 16'd0) begin
            r_state <= S_WAIT_SYNC;
          end else begin
            r_remaining <= w_len;
            r_state     <= S_PIXELS;
          end
        end
        S_PIXELS: begin
          // Dropped bytes still count so the next SYNC lands where expected.
          r_remaining <= r_remaining - 16'd1;
          if (w_drop) begin
            r_ovf <= 1'b1;
          end
          if (w_last_px) begin
            r_state <= S_WAIT_SYNC;
          end
        end
        default: r_state <= S_WAIT_SYNC;
      endcase
    end
  end

  // Pixel storage; contents are don't-care until a write, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {w_last_px, din};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Show-ahead outputs; forced to zero while empty so reset reads as zero.
  always_comb begin
    {pix_last, pix_data} = 9'd0;
    if (!w_empty) begin
      {pix_last, pix_data} = r_mem[r_rd_ptr];
    end
  end

  assign pix_valid    = ~w_empty;
  assign thresh       = r_thresh;
  assign frame_active = (r_state != S_WAIT_SYNC);
  assign ovf_err      = r_ovf;

endmodule
`default_nettype wire

// File: doc/rx_frame_parser.md
RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, pixel FIFO entries (power of two, 4..64).
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 The block SHALL have parameter THRESH_RST, default 8'h80, reset value of thresh.
REQ-004 The block SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, asynchronous and active-low (reset=0 clears the block).
REQ-006 The block SHALL have port rx_done_tick  input  1  one-cycle strobe marking a received byte.
REQ-007 The block SHALL have port din  input  8  received byte, valid only while rx_done_tick=1.
REQ-008 The block SHALL have port pix_data  output  8  FIFO head pixel.
REQ-009 The block SHALL have port pix_last  output  1  head pixel is the final pixel of its frame.
REQ-010 The block SHALL have port pix_valid  output  1  FIFO non-empty.
REQ-011 The block SHALL have port pix_ready  input  1  consumer accepts the head pixel.
REQ-012 The block SHALL have port thresh  output  8  binarization threshold of the current frame.
REQ-013 The block SHALL have port frame_active  output  1  parser is inside a frame (any state except WAIT_SYNC).
REQ-014 The block SHALL have port ovf_err  output  1  sticky flag: a pixel was dropped on a full FIFO.

Function
REQ-015 Frame format SHALL be, in order: SYNC_BYTE, THRESH, LEN_HI, LEN_LO, then LEN pixel bytes; LEN is 16-bit unsigned.
REQ-016 The FSM SHALL have states WAIT_SYNC, GET_THR, GET_LEN_HI, GET_LEN_LO, PIXELS; it advances only on cycles with rx_done_tick=1.
REQ-017 WAIT_SYNC: din==SYNC_BYTE -> GET_THR and ovf_err cleared; any other byte discarded, state held.
REQ-018 GET_THR: din is loaded into thresh in the same cycle -> GET_LEN_HI; thresh holds until the next frame's THRESH byte.
REQ-019 GET_LEN_HI: din stored as LEN[15:8] -> GET_LEN_LO.
REQ-020 GET_LEN_LO: LEN={LEN_HI,din}; LEN==0 -> WAIT_SYNC with no FIFO write; else remaining counter=LEN -> PIXELS.
REQ-021 PIXELS: each byte SHALL be pushed as {last,din}, last=1 when remaining==1; remaining decrements; remaining==1 -> WAIT_SYNC.
REQ-022 Inside a frame, bytes equal to SYNC_BYTE SHALL be treated as data (no resynchronisation).
REQ-023 FIFO SHALL be show-ahead: pix_valid=~empty; pix_data/pix_last SHALL reflect the head entry whenever pix_valid=1.
REQ-024 Pop SHALL occur exactly when pix_valid && pix_ready; pix_data/pix_last SHALL be held stable while pix_valid && ~pix_ready.
REQ-025 Latency: a byte pushed at edge N into an empty FIFO SHALL give pix_valid=1 after edge N (one clock).
REQ-026 Push with FIFO full and no pop the same cycle SHALL drop the byte and set ovf_err; remaining still decrements, so frame alignment is kept.
REQ-027 Push and pop in the same cycle on a full FIFO SHALL both succeed, with occupancy unchanged.
REQ-028 Push and pop in the same cycle on an empty FIFO: the pop SHALL not occur (pix_valid=0); the push SHALL succeed.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy counter.
REQ-030 If the dropped byte carried last=1, no last marker reaches the output; the bench SHALL detect this case via ovf_err.

Reset
REQ-031 While reset=0, regardless of clk: state=WAIT_SYNC, FIFO empty (pix_valid=0), pix_data=0, pix_last=0, thresh=THRESH_RST, frame_active=0, ovf_err=0, LEN and remaining=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame and all FIFO contents; after release the parser SHALL wait for SYNC_BYTE.

Verification
REQ-033 Bytes A5,64,00,03,10,20,30 with pix_ready=1 -> pixels 10,20,30 out, pix_last=1 only on 30, thresh=64, frame_active=0 after the 7th byte.
REQ-034 Bytes 00,FF,A5,80,00,00 -> no pixels, thresh=80, parser back in WAIT_SYNC, frame_active=0.
REQ-035 Default FIFO_DEPTH=16, pix_ready=0, frame LEN=20 -> first 16 pixels held, ovf_err=1, frame_active=0 after byte 20; pix_ready=1 -> 16 pixels drain, none with pix_last=1.
REQ-036 FIFO full, push plus pop in the same cycle -> occupancy stays 16, ovf_err stays 0, output order intact.
REQ-037 Frame LEN=5 with pix_ready toggling every cycle -> pix_data stable while stalled, order preserved, last on the 5th pixel.
REQ-038 reset=0 asynchronously after 2 of 4 pixels -> all outputs at reset values immediately; next frame A5,11,00,01,7F -> single pixel 7F with pix_last=1.
